mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch and load/store for the multi-cycle core.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_lane_align.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter: core word types, func3 encodings,
// arbiter state and access-size decoding.
package mem_port_arbiter_pkg;

  typedef logic [31:0] word;
  typedef logic [31:0] inst_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_func3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_func3_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Loads and stores share the low func3 bits for size; unsupported codes fall back to word.
  function automatic access_size_t access_size(input logic [2:0] func3);
    case (func3)
      3'b000, 3'b100: return SZ_BYTE;
      3'b001, 3'b101: return SZ_HALF;
      default:        return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational lane steering for the data port: byte enables, replicated store data,
// extended load data and the misalignment flag.
module lsu_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       we,
  input  logic [1:0] addr_lo,
  input  word        wdata,
  input  word        rdata,
  output byte_en_t   be,
  output word        wdata_lane,
  output word        rdata_ext,
  output logic       misalign
);

  access_size_t size;
  logic         is_unsigned;
  logic [7:0]   rd_byte;
  logic [15:0]  rd_half;

  assign size        = access_size(func3);
  assign is_unsigned = func3[2];
  assign rd_byte     = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half     = rdata[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        if (we) be = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        if (we) be = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & rd_half[15]}}, rd_half};
        misalign   = addr_lo[0];
      end
      default: misalign = |addr_lo;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Optional feature: define MISALIGN_TRAP_EN to answer misaligned data requests with d_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_rsp,
  output inst_t       if_inst,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output byte_en_t    mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             lat_data;
  logic             lat_we;
  logic [2:0]       lat_func3;
  logic [1:0]       lat_addr_lo;

  logic       grant_data;
  logic       grant_fetch;
  logic       trap;
  logic [2:0] al_func3;
  logic       al_we;
  logic [1:0] al_addr_lo;
  byte_en_t   al_be;
  word        al_wdata;
  word        al_rdata;
  logic       al_misalign;

  // Data wins unless fetch has already waited through STARVE_LIMIT data grants.
  assign grant_data  = (state == ARB_IDLE) && d_valid && !(if_valid && starve_cnt == CNT_MAX);
  assign grant_fetch = (state == ARB_IDLE) && if_valid && !grant_data;

  // In IDLE the aligner sees the live request (for issue); afterwards the latched one (for load data).
  assign al_func3   = (state == ARB_IDLE) ? d_func3     : lat_func3;
  assign al_we      = (state == ARB_IDLE) ? d_we        : lat_we;
  assign al_addr_lo = (state == ARB_IDLE) ? d_addr[1:0] : lat_addr_lo;

  lsu_lane_align u_align (
    .func3      (al_func3),
    .we         (al_we),
    .addr_lo    (al_addr_lo),
    .wdata      (d_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misalign   (al_misalign)
  );

`ifdef MISALIGN_TRAP_EN
  assign trap = al_misalign;
`else
  logic misalign_unused;
  assign trap            = 1'b0;
  assign misalign_unused = al_misalign;
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      starve_cnt  <= '0;
      lat_data    <= 1'b0;
      lat_we      <= 1'b0;
      lat_func3   <= '0;
      lat_addr_lo <= '0;
      if_rsp      <= 1'b0;
      if_inst     <= '0;
      d_rsp       <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      if (!if_valid || grant_fetch) starve_cnt <= '0;
      else if (grant_data)          starve_cnt <= starve_cnt + 1'b1;

      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            lat_data    <= 1'b1;
            lat_we      <= d_we;
            lat_func3   <= d_func3;
            lat_addr_lo <= d_addr[1:0];
            if (trap) begin
              state   <= ARB_RESP;
              d_rsp   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state     <= ARB_ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_be    <= al_be;
              mem_addr  <= d_addr & ~32'h3;
              mem_wdata <= d_we ? al_wdata : '0;
            end
          end else if (grant_fetch) begin
            lat_data  <= 1'b0;
            lat_we    <= 1'b0;
            state     <= ARB_ISSUE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= if_addr & ~32'h3;
            mem_wdata <= '0;
          end
        end
        ARB_ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_done) begin
            state <= ARB_RESP;
            if (lat_data) begin
              d_rsp   <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= lat_we ? '0 : al_rdata;
            end else begin
              if_rsp  <= 1'b1;
              if_inst <= mem_rdata;
            end
          end
        end
        ARB_RESP: begin
          if_rsp <= 1'b0;
          d_rsp  <= 1'b0;
          d_err  <= 1'b0;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rsp;
  inst_t       if_inst;
  logic        d_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_func3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_rsp;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  byte_en_t    mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_rsp(if_rsp), .if_inst(if_inst),
    .d_valid(d_valid), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp(d_rsp), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic on the access rules) ----------------
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int lo = int'(a % 4);
    if (!we || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << lo);
    return 4'(3 << (lo & 2));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_of(f3);
    if (sz == 1) return {4{wd[7:0]}};
    if (sz == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz = size_of(f3);
    int lo = int'(a % 4);
    int val;
    logic [31:0] v;
    if (sz == 4) return rd;
    v = (sz == 1) ? rd >> (8 * lo) : rd >> (8 * (lo & 2));
    if (sz == 1) begin
      val = int'(v % 256);
      if (!f3[2] && val >= 128) val -= 256;
    end else begin
      val = int'(v % 65536);
      if (!f3[2] && val >= 32768) val -= 65536;
    end
    return 32'(val);
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a % 4) % size_of(f3)) != 0;
  endfunction

  typedef struct {
    bit          is_data;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          trap;
  } txn_t;

  txn_t        cur;
  bit          busy, accepted, rsp_due, just_done, exp_req, g_data;
  logic [31:0] rdata_cap;
  int          cnt, cyc, req_cycles, last_req_cycles, acc_count;
  bit          grants[$];
  int          rsp_cycles[$];
  logic [31:0] last_if_inst, last_d_rdata, last_acc_addr, last_acc_wdata;
  logic        last_d_err;
  logic [3:0]  last_acc_be;

  initial begin
    busy = 0; accepted = 0; rsp_due = 0; cnt = 0; cyc = 0; acc_count = 0;
    req_cycles = 0; last_req_cycles = 0;
  end

  // Compare process: one pass per cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 0; accepted = 0; rsp_due = 0; cnt = 0;
    end else begin
      check("if_rsp", if_rsp, rsp_due && !cur.is_data);
      check("d_rsp", d_rsp, rsp_due && cur.is_data);
      just_done = rsp_due;
      if (rsp_due) begin
        if (cur.is_data) begin
          check("d_rdata", d_rdata, (cur.we || cur.trap) ? 32'h0 : exp_load(cur.f3, cur.addr, rdata_cap));
          check("d_err", d_err, cur.trap);
          last_d_rdata = d_rdata;
          last_d_err   = d_err;
        end else begin
          check("if_inst", if_inst, rdata_cap);
          last_if_inst = if_inst;
        end
        rsp_cycles.push_back(cyc);
        busy = 0; rsp_due = 0;
      end

      exp_req = busy && !accepted && !cur.trap;
      check("mem_req", mem_req, exp_req);
      if (exp_req) begin
        req_cycles++;
        check("mem_addr", mem_addr, cur.addr & ~32'h3);
        check("mem_we", mem_we, cur.we);
        check("mem_be", mem_be, exp_be(cur.we, cur.f3, cur.addr));
        if (cur.we) check("mem_wdata", mem_wdata, exp_wdata(cur.f3, cur.wd));
        if (mem_ready) begin
          accepted = 1; acc_count++; last_req_cycles = req_cycles;
          last_acc_addr = mem_addr; last_acc_be = mem_be; last_acc_wdata = mem_wdata;
        end
      end else if (busy && accepted && !rsp_due && mem_done) begin
        rsp_due = 1; rdata_cap = mem_rdata;
      end

      g_data = 0;
      if (!busy && !just_done && (if_valid || d_valid)) begin
        g_data = d_valid && !(if_valid && cnt == STARVE);
        busy = 1; accepted = 0; req_cycles = 0;
        if (g_data) begin
          cur.is_data = 1; cur.we = d_we; cur.f3 = d_func3; cur.addr = d_addr; cur.wd = d_wdata;
          cur.trap = TRAP_EN && misaligned(d_func3, d_addr);
          if (cur.trap) rsp_due = 1;
        end else begin
          cur.is_data = 0; cur.we = 0; cur.f3 = 3'b010; cur.addr = if_addr; cur.wd = '0;
          cur.trap = 0;
        end
        grants.push_back(g_data);
        if (!if_valid) cnt = 0;
        else if (g_data) cnt++;
        else cnt = 0;
      end else if (!if_valid) begin
        cnt = 0;
      end
    end
  end

  // ---------------- stimulus: memory responder and requesters, one driver process ----------------
  int          rdy_pct = 100, done_min = 1, done_max = 1, done_cnt = 0, stall = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_rdata = '0;
  bit          f_auto = 0, d_auto = 0;
  int          f_pct = 0, d_pct = 0, f_done = 0, d_done = 0;

  task automatic step();
    @(posedge clk);
    #1;
    mem_done = 1'b0;
    if (!rst_n) done_cnt = 0;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        mem_done  = 1'b1;
        mem_rdata = use_fixed ? fixed_rdata : $urandom;
      end
    end
    if (mem_req && stall > 0) begin
      mem_ready = 1'b0;
      stall--;
    end else begin
      mem_ready = ($urandom_range(99) < rdy_pct);
    end
    if (rst_n && mem_req && mem_ready) done_cnt = $urandom_range(done_max, done_min);

    if (if_valid && if_rsp) begin if_valid = 1'b0; f_done++; end
    if (!if_valid && f_auto && $urandom_range(99) < f_pct) begin
      if_valid = 1'b1; if_addr = $urandom;
    end
    if (d_valid && d_rsp) begin d_valid = 1'b0; d_done++; end
    if (!d_valid && d_auto && $urandom_range(99) < d_pct) begin
      d_valid = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_func3 = d_we ? 3'($urandom_range(2)) : 3'($urandom_range(7));
      if (d_we && $urandom_range(9) == 0) d_func3 = 3'b011;
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget && (if_valid || d_valid); i++) step();
    @(negedge clk);
    #1;
  endtask

  task automatic data_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    d_valid = 1'b1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
  endtask

  int f0, d0, a0;
  bit pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    // reset state
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_rsp", {if_rsp, d_rsp, d_err, mem_we}, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_d_rdata", d_rdata, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // model pins
    check("model_lh", exp_load(3'b001, 32'h202, 32'h80011234), 32'hFFFF8001);
    check("model_lbu", exp_load(3'b100, 32'h203, 32'h80011234), 32'h00000080);
    check("model_sb_be", exp_be(1'b1, 3'b000, 32'h203), 4'b1000);

    // fetch with fixed memory timing
    use_fixed = 1; fixed_rdata = 32'h00500093; rdy_pct = 100; done_min = 2; done_max = 2;
    f0 = f_done;
    if_addr = 32'h100; if_valid = 1'b1;
    run_until_idle(50);
    check("t1_done", f_done, f0 + 1);
    check("t1_inst", last_if_inst, 32'h00500093);
    check("t1_be", last_acc_be, 4'hF);
    check("t1_addr", last_acc_addr, 32'h100);

    // store byte and load half
    done_min = 1; done_max = 2;
    d0 = d_done;
    data_req(1'b1, 3'b000, 32'h203, 32'h000000AB);
    run_until_idle(50);
    check("t2_sb_done", d_done, d0 + 1);
    check("t2_sb_addr", last_acc_addr, 32'h200);
    check("t2_sb_be", last_acc_be, 4'b1000);
    check("t2_sb_wdata", last_acc_wdata, 32'hABABABAB);
    fixed_rdata = 32'h80011234;
    data_req(1'b0, 3'b001, 32'h202, 32'h0);
    run_until_idle(50);
    check("t2_lh_rdata", last_d_rdata, 32'hFFFF8001);

    // misaligned word store
    a0 = acc_count;
    d0 = d_done;
    data_req(1'b1, 3'b010, 32'h106, 32'h12345678);
    run_until_idle(50);
    check("t4_done", d_done, d0 + 1);
`ifdef MISALIGN_TRAP_EN
    check("t4_no_access", acc_count, a0);
    check("t4_err", last_d_err, 1'b1);
    check("t4_rdata", last_d_rdata, 32'h0);
`else
    check("t4_addr", last_acc_addr, 32'h104);
    check("t4_be", last_acc_be, 4'hF);
    check("t4_err", last_d_err, 1'b0);
`endif

    // memory stalls acceptance for 5 cycles
    stall = 5;
    d0 = d_done;
    data_req(1'b0, 3'b010, 32'h300, 32'h0);
    run_until_idle(60);
    check("t5_done", d_done, d0 + 1);
    check("t5_req_cycles", last_req_cycles, 6);
    check("t5_rdata", last_d_rdata, 32'h80011234);

    // both requesters held: starvation pattern and 4-cycle throughput
    use_fixed = 0; done_min = 1; done_max = 1; rdy_pct = 100;
    grants.delete(); rsp_cycles.delete();
    f_auto = 1; d_auto = 1; f_pct = 100; d_pct = 100;
    for (int i = 0; i < 200 && grants.size() < 11; i++) step();
    f_auto = 0; d_auto = 0;
    run_until_idle(100);
    check("t3_grants", grants.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check($sformatf("t3_grant_%0d", i), grants[i], pat[i]);
    for (int i = 0; i < 8 && i + 1 < rsp_cycles.size(); i++)
      check($sformatf("t3_spacing_%0d", i), rsp_cycles[i + 1] - rsp_cycles[i], 4);

    // reset while waiting on memory
    use_fixed = 1; fixed_rdata = 32'hCAFEF00D; done_min = 3; done_max = 3;
    a0 = acc_count;
    if_addr = 32'h400; if_valid = 1'b1;
    for (int i = 0; i < 20 && acc_count == a0; i++) step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_mem_req", mem_req, 0);
    check("t6_rsp", {if_rsp, d_rsp, d_err, mem_we}, 0);
    check("t6_mem_be", mem_be, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_if_inst", if_inst, 0);
    check("t6_d_rdata", d_rdata, 0);
    if_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    fixed_rdata = 32'h0BADF00D;
    f0 = f_done;
    if_addr = 32'h500; if_valid = 1'b1;
    run_until_idle(50);
    check("t6_after_done", f_done, f0 + 1);
    check("t6_after_inst", last_if_inst, 32'h0BADF00D);

    // randomized traffic
    use_fixed = 0; rdy_pct = 60; done_min = 1; done_max = 3;
    f_auto = 1; d_auto = 1; f_pct = 40; d_pct = 50;
    f0 = f_done; d0 = d_done;
    repeat (3000) step();
    f_auto = 0; d_auto = 0;
    run_until_idle(200);
    check("rand_drained", {if_valid, d_valid}, 0);
    check("rand_progress", (f_done - f0 > 50) && (d_done - d0 > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
